// File: rtl/xor_mismatch_counter_pkg.sv
// Shared definitions for the XOR bit-error checker: datapath width and FSM encodings.
// The XOR stage, the mismatch counter and its bench all import this package.
package xor_mismatch_counter_pkg;

  localparam int XS_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/xor_mismatch_counter_popcount.sv
// Purely combinational population count of a WIDTH-bit vector.
// Output is wide enough to hold WIDTH itself.
module popcount_n #(
  parameter  int WIDTH = 4,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] x_i,
  output logic [CW-1:0]    count_o
);

  always_comb begin
    // NOTE: give every always_comb output a default first so no path can infer a latch.
    count_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count_o = count_o + CW'(x_i[i]);
    end
  end

endmodule

// File: rtl/xor_mismatch_counter.sv
// Bit-error checker behind the XOR stage: sums popcount(x) over a window of valid
// samples into a saturating total, pulsing done one cycle after the final count.
module xor_mismatch_counter
  import xor_mismatch_counter_pkg::*;
#(
  parameter int WIDTH = XS_WIDTH,
  parameter int CNT_W = 16,
  parameter int WIN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_count,
  output logic             sat
);

  localparam int PC_W = $clog2(WIDTH + 1);

  state_e           state_q;
  logic [WIN_W-1:0] remain_q;
  logic [CNT_W-1:0] err_q, err_d;
  logic             sat_q, sat_d;
  logic             busy_q, done_q;

  logic [WIDTH-1:0] x_gated;
  logic [PC_W-1:0]  pc;
  logic [CNT_W:0]   sum;

  // Gate x with in_valid so an X on an idle bus can never reach the accumulator.
  assign x_gated = in_valid ? x : '0;

  popcount_n #(.WIDTH(WIDTH)) u_popcount (
    .x_i     (x_gated),
    .count_o (pc)
  );

  always_comb begin
    sum   = {1'b0, err_q} + {{(CNT_W + 1 - PC_W){1'b0}}, pc};
    err_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    sat_d = sat_q | (&err_d);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  // NOTE: all registers here are control/accumulator flops and are reset; there is no memory array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      remain_q <= '0;
      err_q    <= '0;
      sat_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && (win_len != '0)) begin
            remain_q <= win_len;
            err_q    <= '0;
            sat_q    <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
          end
        end
        S_RUN: begin
          if (in_valid) begin
            err_q    <= err_d;
            sat_q    <= sat_d;
            remain_q <= remain_q - WIN_W'(1);
            if (remain_q == WIN_W'(1)) begin
              busy_q  <= 1'b0;
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          // done follows the final count by one cycle, as seen at the outputs.
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err_count = err_q;
  assign sat       = sat_q;

endmodule
